// File: rtl/p_bit_array.sv
// ---------------------------------------------------------------------------
// p_bit_array
//   Bank of N probabilistic bits (p-bits) for Ising / sIM sampling. Each
//   channel scales its signed local field by 2^beta, saturates the result to
//   [-2^(RNG_W-1), +2^(RNG_W-1)] and compares it against a per-channel Galois
//   LFSR sample. A channel's new state is 1 when the scaled field exceeds the
//   sample.
//
//   Update modes:
//     mode = 0 : parallel - every channel updates on each enabled step.
//     mode = 1 : sequential Gibbs - only channel upd_idx updates per step.
//
//   Optional build macro ANNEAL_EN:
//     Adds a sweep counter. Every ANNEAL_PER sweep_done pulses, an internal
//     beta increment rises by one (saturating), so that
//     beta = min(bit_shift + beta_inc, MAX_SHIFT). Without the macro,
//     beta = min(bit_shift, MAX_SHIFT) purely combinationally.
//
// Ports
//   clk         in   1          rising-edge clock
//   reset       in   1          synchronous, active-low reset
//   en          in   1          one update step per cycle while high
//   mode        in   1          0 = parallel, 1 = sequential round-robin
//   input_val   in   N*IN_W     packed signed fields, channel i at [i*IN_W +: IN_W]
//   bit_shift   in   SH_W       base shift (inverse temperature)
//   out         out  N          p-bit states (1 = +1 spin, 0 = -1 spin)
//   upd_idx     out  clog2(N)   channel updated by the next sequential step
//   sweep_done  out  1          one-cycle pulse when a full sweep completes
//   beta        out  SH_W       effective shift in use
// ---------------------------------------------------------------------------
module p_bit_array #(
    parameter int unsigned       N          = 8,
    parameter int unsigned       IN_W       = 4,
    parameter int unsigned       RNG_W      = 8,
    parameter int unsigned       MAX_SHIFT  = 3,
    parameter logic [RNG_W-1:0]  SEED       = RNG_W'(8'hA5),
    parameter int unsigned       ANNEAL_PER = 4,
    localparam int unsigned      SH_W       = $clog2(MAX_SHIFT + 1),
    localparam int unsigned      IDX_W      = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  mode,
    input  logic [N*IN_W-1:0]     input_val,
    input  logic [SH_W-1:0]       bit_shift,
    output logic [N-1:0]          out,
    output logic [IDX_W-1:0]      upd_idx,
    output logic                  sweep_done,
    output logic [SH_W-1:0]       beta
);

    // Width of the shifted field, of the saturated comparison value, and a
    // working width large enough to hold either without overflow.
    localparam int unsigned SW = IN_W + MAX_SHIFT;
    localparam int unsigned CW = RNG_W + 1;
    localparam int unsigned WW = ((SW > CW) ? SW : CW) + 1;

    localparam logic signed [WW-1:0] POS_LIM = WW'(2 ** (RNG_W - 1));
    localparam logic signed [WW-1:0] NEG_LIM = -POS_LIM;

    // Right-shift Galois masks for maximal-length polynomials:
    //   8 bit : x^8  + x^6  + x^5  + x^4 + 1
    //   16 bit: x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [RNG_W-1:0] TAPS = (RNG_W == 16) ? RNG_W'(16'hB400)
                                                      : RNG_W'(8'hB8);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    if (N < 2 || ANNEAL_PER < 1) begin : g_param_check
        $error("p_bit_array: N must be >= 2 and ANNEAL_PER >= 1");
    end

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    function automatic logic [RNG_W-1:0] seed_of(input int unsigned ch);
        logic [RNG_W-1:0] s;
        s = SEED ^ RNG_W'(ch * 32'h3B);
        if (s == '0) begin
            s = RNG_W'(1);
        end
        return s;
    endfunction

    function automatic logic [RNG_W-1:0] lfsr_step(input logic [RNG_W-1:0] s);
        return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    endfunction

    // -----------------------------------------------------------------------
    // Effective shift
    // -----------------------------------------------------------------------
    logic [SH_W-1:0] beta_eff;

`ifdef ANNEAL_EN
    localparam int unsigned CNT_W = (ANNEAL_PER > 1) ? $clog2(ANNEAL_PER) : 1;
    localparam int unsigned SUM_W = SH_W + 1;

    logic [CNT_W-1:0] sweep_cnt;
    logic [SH_W-1:0]  beta_inc;
    logic [SUM_W-1:0] beta_sum;

    // Counts registered sweep_done pulses, so an increment becomes visible
    // the cycle after the ANNEAL_PER-th pulse has been seen.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sweep_cnt <= '0;
            beta_inc  <= '0;
        end else if (sweep_done) begin
            if (sweep_cnt == CNT_W'(ANNEAL_PER - 1)) begin
                sweep_cnt <= '0;
                if (beta_inc != SH_W'(MAX_SHIFT)) begin
                    beta_inc <= beta_inc + SH_W'(1);
                end
            end else begin
                sweep_cnt <= sweep_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        beta_sum = SUM_W'(bit_shift) + SUM_W'(beta_inc);
        beta_eff = (beta_sum > SUM_W'(MAX_SHIFT)) ? SH_W'(MAX_SHIFT)
                                                  : beta_sum[SH_W-1:0];
    end
`else
    always_comb begin
        beta_eff = (bit_shift > SH_W'(MAX_SHIFT)) ? SH_W'(MAX_SHIFT) : bit_shift;
    end
`endif

    assign beta = beta_eff;

    // -----------------------------------------------------------------------
    // Per-channel field path and decision
    // -----------------------------------------------------------------------
    logic [RNG_W-1:0]        lfsr_q  [N];
    logic signed [SW-1:0]    shf     [N];
    logic signed [WW-1:0]    wide    [N];
    logic signed [WW-1:0]    sat     [N];
    logic signed [WW-1:0]    rnd     [N];
    logic [N-1:0]            new_out;

    always_comb begin
        new_out = '0;
        for (int unsigned i = 0; i < N; i++) begin
            shf[i]  = {{MAX_SHIFT{input_val[i*IN_W + IN_W - 1]}},
                       input_val[i*IN_W +: IN_W]} <<< beta_eff;
            wide[i] = {{(WW - SW){shf[i][SW-1]}}, shf[i]};
            if (wide[i] > POS_LIM) begin
                sat[i] = POS_LIM;
            end else if (wide[i] < NEG_LIM) begin
                sat[i] = NEG_LIM;
            end else begin
                sat[i] = wide[i];
            end
            rnd[i]     = {{(WW - RNG_W){lfsr_q[i][RNG_W-1]}}, lfsr_q[i]};
            new_out[i] = (sat[i] > rnd[i]);
        end
    end

    // -----------------------------------------------------------------------
    // State: LFSRs, spins, sequential pointer, sweep pulse
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            out        <= '0;
            upd_idx    <= '0;
            sweep_done <= 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                lfsr_q[i] <= seed_of(i);
            end
        end else if (en) begin
            // LFSRs advance on every step in both modes so the random streams
            // stay independent of the update schedule.
            for (int unsigned i = 0; i < N; i++) begin
                lfsr_q[i] <= lfsr_step(lfsr_q[i]);
            end
            if (mode) begin
                out[upd_idx] <= new_out[upd_idx];
                upd_idx      <= (upd_idx == LAST_IDX) ? '0 : upd_idx + IDX_W'(1);
                sweep_done   <= (upd_idx == LAST_IDX);
            end else begin
                // upd_idx is deliberately left alone so a sequential sweep
                // can resume where it stopped after a parallel interlude.
                out        <= new_out;
                sweep_done <= 1'b1;
            end
        end else begin
            sweep_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_p_bit_array.sv
// ---------------------------------------------------------------------------
// tb_p_bit_array
//   Directed stimulus for p_bit_array with a behavioural reference model
//   (integer arithmetic on fields, LFSR sequences as plain integers) that is
//   compared against every output on every cycle, plus hand-computed literal
//   expectations for the first LFSR-driven decisions after reset.
// ---------------------------------------------------------------------------
module tb_p_bit_array;

    localparam int N         = 8;
    localparam int IN_W      = 4;
    localparam int RNG_W     = 8;
    localparam int MAX_SHIFT = 3;
    localparam int SH_W      = 2;
    localparam int IDX_W     = 3;

    logic                 clk;
    logic                 reset;
    logic                 en;
    logic                 mode;
    logic [N*IN_W-1:0]    input_val;
    logic [SH_W-1:0]      bit_shift;
    logic [N-1:0]         out;
    logic [IDX_W-1:0]     upd_idx;
    logic                 sweep_done;
    logic [SH_W-1:0]      beta;

    int checks;
    int passed;

    p_bit_array #(
        .N          (N),
        .IN_W       (IN_W),
        .RNG_W      (RNG_W),
        .MAX_SHIFT  (MAX_SHIFT),
        .SEED       (8'hA5),
        .ANNEAL_PER (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .mode       (mode),
        .input_val  (input_val),
        .bit_shift  (bit_shift),
        .out        (out),
        .upd_idx    (upd_idx),
        .sweep_done (sweep_done),
        .beta       (beta)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model
    // -----------------------------------------------------------------------
    int            m_lfsr [N];
    logic [N-1:0]  m_out;
    int            m_idx;
    logic          m_sd;
    int            m_sweeps;

    function automatic int seed(input int ch);
        int s;
        s = 'hA5 ^ ((ch * 59) & 255);
        if (s == 0) s = 1;
        return s;
    endfunction

    function automatic int lfsr_next(input int x);
        if ((x & 1) != 0) return (x >> 1) ^ 'hB8;
        return x >> 1;
    endfunction

    function automatic int field(input int ch);
        int v;
        v = int'((input_val >> (ch * IN_W)) & 32'hF);
        if (v >= 8) v -= 16;
        return v;
    endfunction

    function automatic int model_beta();
        int b;
        b = int'(bit_shift);
`ifdef ANNEAL_EN
        b += (m_sweeps / 4 > MAX_SHIFT) ? MAX_SHIFT : m_sweeps / 4;
`endif
        if (b > MAX_SHIFT) b = MAX_SHIFT;
        return b;
    endfunction

    function automatic logic decide(input int ch, input int b);
        int s;
        int r;
        s = field(ch) * (1 << b);
        if (s > 128)  s = 128;
        if (s < -128) s = -128;
        r = (m_lfsr[ch] >= 128) ? m_lfsr[ch] - 256 : m_lfsr[ch];
        return s > r;
    endfunction

    always @(posedge clk) begin : model_blk
        int b;
        logic [N-1:0] nv;
        if (!reset) begin
            for (int i = 0; i < N; i++) m_lfsr[i] = seed(i);
            m_out    = '0;
            m_idx    = 0;
            m_sd     = 1'b0;
            m_sweeps = 0;
        end else begin
            b = model_beta();
            for (int i = 0; i < N; i++) nv[i] = decide(i, b);
            if (m_sd) m_sweeps++;
            if (en) begin
                if (mode) begin
                    m_out[m_idx] = nv[m_idx];
                    m_sd  = (m_idx == N - 1);
                    m_idx = (m_idx + 1) % N;
                end else begin
                    m_out = nv;
                    m_sd  = 1'b1;
                end
                for (int i = 0; i < N; i++) m_lfsr[i] = lfsr_next(m_lfsr[i]);
            end else begin
                m_sd = 1'b0;
            end
        end
    end

    always @(posedge clk) begin : compare_blk
        #1;
        check("out",        out,        m_out);
        check("upd_idx",    upd_idx,    m_idx);
        check("sweep_done", sweep_done, m_sd);
        check("beta",       beta,       model_beta());
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [N*IN_W-1:0] all_fields(input logic [IN_W-1:0] f);
        logic [N*IN_W-1:0] v;
        for (int i = 0; i < N; i++) v[i*IN_W +: IN_W] = f;
        return v;
    endfunction

    logic [N*IN_W-1:0] vec_tab   [4];
    logic [SH_W-1:0]   shift_tab [4];
    int                ones      [N];
    logic [N-1:0]      frozen;
    int                ak        [5];
    int                ab        [5];

    initial begin
        checks    = 0;
        passed    = 0;
        reset     = 1'b0;
        en        = 1'b1;
        mode      = 1'b0;
        input_val = '0;
        bit_shift = '0;

        vec_tab[0] = 32'h7F80_3C21;  shift_tab[0] = 2'd1;
        vec_tab[1] = 32'h8888_7777;  shift_tab[1] = 2'd2;
        vec_tab[2] = 32'h1234_ABCD;  shift_tab[2] = 2'd0;
        vec_tab[3] = 32'hF0E1_D2C3;  shift_tab[3] = 2'd3;

        // Reset held 3 cycles with en high
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_out",   out,        0);
            check("rst_idx",   upd_idx,    0);
            check("rst_sweep", sweep_done, 0);
        end

        // First two parallel steps with zero fields expose the seeds:
        // out bit = LFSR msb. Seeds A5 9E D3 14 49 82 C7 38 -> 8'h67,
        // next states EA 4F D1 0A 9C 41 DB 1C -> 8'h55.
        reset = 1'b1;
        tick();
        check("seed_out",   out,        8'h67);
        check("seed_sweep", sweep_done, 1);
        tick();
        check("lfsr1_out",  out,        8'h55);

        // Fields +7, shift 3 -> s=56 against 75 9F D0 05 4E 98 D5 0E
        input_val = all_fields(4'h7);
        bit_shift = 2'd3;
        tick();
        check("par_pos_out", out, 8'hEE);
        check("par_beta",    beta, 3);
        // Fields -8, shift 3 -> s=-64 against 82 F7 68 BA 27 4C D2 07
        input_val = all_fields(4'h8);
        tick();
        check("par_neg_out",   out,        8'h09);
        check("par_neg_sweep", sweep_done, 1);

        // Mixed directed vectors, checked by the model
        for (int v = 0; v < 4; v++) begin
            input_val = vec_tab[v];
            bit_shift = shift_tab[v];
            repeat (3) tick();
        end

        // Sequential sweep from a clean state
        reset = 1'b0;
        tick();
        reset     = 1'b1;
        mode      = 1'b1;
        input_val = all_fields(4'h7);
        bit_shift = 2'd3;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check("seq_idx",   upd_idx,    k % N);
            check("seq_sweep", sweep_done, (k == N) ? 1 : 0);
            if (k < N) check("seq_untouched", out >> k, 0);
        end

        // Parallel interlude keeps the sequential pointer
        mode = 1'b0;
        tick();
        check("mix_idx_kept", upd_idx,    1);
        check("mix_sweep",    sweep_done, 1);
        mode = 1'b1;
        tick();
        check("mix_idx_next", upd_idx, 2);

        // Reset in the middle of a sweep
        repeat (3) tick();
        check("mid_idx5", upd_idx, 5);
        reset = 1'b0;
        tick();
        check("mid_rst_idx",   upd_idx,    0);
        check("mid_rst_out",   out,        0);
        check("mid_rst_sweep", sweep_done, 0);
        reset = 1'b1;

        // Long parallel run with zero field: ~50% ones per channel
        mode      = 1'b0;
        input_val = '0;
        bit_shift = 2'd0;
        for (int i = 0; i < N; i++) ones[i] = 0;
        for (int k = 0; k < 4096; k++) begin
            if (k == 2000) begin
                frozen = out;
                en = 1'b0;
                for (int p = 0; p < 10; p++) begin
                    tick();
                    check("hold_out",   out,        frozen);
                    check("hold_sweep", sweep_done, 0);
                end
                en = 1'b1;
            end
            tick();
            for (int i = 0; i < N; i++) ones[i] += int'(out[i]);
        end
        for (int i = 0; i < N; i++) begin
            check("ones_in_band", (ones[i] >= 1848 && ones[i] <= 2248) ? 1 : 0, 1);
        end

`ifdef ANNEAL_EN
        ak[0] = 4;  ab[0] = 0;
        ak[1] = 5;  ab[1] = 1;
        ak[2] = 9;  ab[2] = 2;
        ak[3] = 13; ab[3] = 3;
        ak[4] = 20; ab[4] = 3;
        reset     = 1'b0;
        bit_shift = 2'd0;
        mode      = 1'b0;
        tick();
        check("anneal_rst_beta", beta, 0);
        reset = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            for (int j = 0; j < 5; j++) begin
                if (ak[j] == k) check("anneal_beta", beta, ab[j]);
            end
        end
`else
        ak[0] = 0;
        ab[0] = 0;
`endif

        en = 1'b0;
        repeat (2) tick();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
